fetch_decode_ctrl: RTL

Sequencer for the fetch/decode front end. Drives the load/clear strobes of the fetch register, the decode register and the branch-target register, plus the instruction-memory request and PC update. Tracks stage valid bits, stalls on execute back-pressure, flushes on taken branches and stops on a halt opcode. Sits between instruction memory, the decode stage and execute.

---
 rtl/fetch_decode_ctrl_pkg.sv | 24 ++
 rtl/fdc_sat_counter.sv | 21 ++
 rtl/fetch_decode_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared definitions for the fetch/decode front-end sequencer:
// state encoding, halt/branch opcode classes and counter width.
package fetch_decode_ctrl_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fdcState_t;

  localparam logic [OP_W-1:0] HALT_OP    = 5'b11111;
  localparam logic [OP_W-1:0] BR_OP_MASK = 5'b11000;
  localparam logic [OP_W-1:0] BR_OP_VAL  = 5'b11000;

  // Branch class: masked opcode bits match the branch value.
  function automatic logic isBranch(input logic [OP_W-1:0] op);
    return (op & BR_OP_MASK) == BR_OP_VAL;
  endfunction

endpackage

// File: rtl/fdc_sat_counter.sv
// 16-bit saturating event counter.
// Ports: clk, clrn (sync active-low clear), en (count enable), count (value).
module fdc_sat_counter
  import fetch_decode_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode front-end sequencer.
// Drives fetch, decode and branch-target register strobes, the instruction
// memory request and PC update; handles stall, branch flush and halt.
// Ports:
//   clk, clrn (sync active-low reset)
//   imemRdy, opcode, exStall, brTaken        : inputs
//   imemReq, ldPC, pcSel                      : memory request / PC update
//   ldInst/clrInst, ldDecodeInst/clrDecodeInst, ldBrnchTrgt/clrBrnchTrgt
//   decValid, halted                          : status
//   stallCnt, flushCnt                        : perf counters
// Build option: FDC_PERF_CNT_EN enables the counters; otherwise they read 0.
module fetch_decode_ctrl
  import fetch_decode_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             imemRdy,
  input  logic [OP_W-1:0]  opcode,
  input  logic             exStall,
  input  logic             brTaken,
  output logic             imemReq,
  output logic             ldPC,
  output logic             pcSel,
  output logic             ldInst,
  output logic             clrInst,
  output logic             ldDecodeInst,
  output logic             clrDecodeInst,
  output logic             ldBrnchTrgt,
  output logic             clrBrnchTrgt,
  output logic             decValid,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  fdcState_t state, nextState;
  logic fValid, fValidNxt;
  logic dValid, dValidNxt;
  logic haltPend, haltPendNxt;

  // Pipeline transfer terms.
  logic advance, ldDecTerm, fetchOk, brTerm, haltCond;
  assign advance   = !dValid || !exStall;
  assign ldDecTerm = advance && fValid;
  assign fetchOk   = !fValid || ldDecTerm;
  assign brTerm    = dValid && isBranch(opcode) && advance;
  assign haltCond  = dValid && (opcode == HALT_OP) && !exStall && !brTaken;

  assign decValid = dValid;

  // State and stage-valid registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= IDLE;
      fValid   <= 1'b0;
      dValid   <= 1'b0;
      haltPend <= 1'b0;
    end else begin
      state    <= nextState;
      fValid   <= fValidNxt;
      dValid   <= dValidNxt;
      haltPend <= haltPendNxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    nextState     = state;
    fValidNxt     = fValid;
    dValidNxt     = dValid;
    haltPendNxt   = haltPend;
    imemReq       = 1'b0;
    ldPC          = 1'b0;
    pcSel         = 1'b0;
    ldInst        = 1'b0;
    clrInst       = 1'b0;
    ldDecodeInst  = 1'b0;
    clrDecodeInst = 1'b0;
    ldBrnchTrgt   = 1'b0;
    clrBrnchTrgt  = 1'b0;
    halted        = 1'b0;

    case (state)
      IDLE: begin
        clrInst       = 1'b1;
        clrDecodeInst = 1'b1;
        clrBrnchTrgt  = 1'b1;
        fValidNxt     = 1'b0;
        dValidNxt     = 1'b0;
        haltPendNxt   = 1'b0;
        nextState     = FETCH;
      end

      FETCH: begin
        imemReq = fetchOk;
        if (brTaken) begin
          clrInst       = 1'b1;
          clrDecodeInst = 1'b1;
          clrBrnchTrgt  = 1'b1;
          ldPC          = 1'b1;
          pcSel         = 1'b1;
          fValidNxt     = 1'b0;
          dValidNxt     = 1'b0;
          nextState     = (imemReq && !imemRdy) ? FLUSH : FETCH;
        end else if (haltCond) begin
          // Halt leaves to execute; any response this cycle is dropped.
          clrInst      = 1'b1;
          ldDecodeInst = ldDecTerm;
          ldBrnchTrgt  = brTerm;
          fValidNxt    = 1'b0;
          if (advance) dValidNxt = fValid;
          if (imemReq && !imemRdy) begin
            haltPendNxt = 1'b1;
            nextState   = FLUSH;
          end else begin
            nextState   = HALT;
          end
        end else begin
          ldInst       = imemReq && imemRdy;
          ldPC         = imemReq && imemRdy;
          ldDecodeInst = ldDecTerm;
          ldBrnchTrgt  = brTerm;
          if (advance) dValidNxt = fValid;
          if (ldInst) fValidNxt = 1'b1;
          else if (ldDecTerm) fValidNxt = 1'b0;
        end
      end

      FLUSH: begin
        // Wait out the abandoned request; its data is never loaded.
        imemReq = 1'b1;
        if (brTaken) begin
          clrInst       = 1'b1;
          clrDecodeInst = 1'b1;
          clrBrnchTrgt  = 1'b1;
          ldPC          = 1'b1;
          pcSel         = 1'b1;
          fValidNxt     = 1'b0;
          dValidNxt     = 1'b0;
        end else begin
          ldDecodeInst = ldDecTerm;
          ldBrnchTrgt  = brTerm;
          if (advance) dValidNxt = fValid;
        end
        if (imemRdy) begin
          nextState   = haltPend ? HALT : FETCH;
          haltPendNxt = 1'b0;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

`ifdef FDC_PERF_CNT_EN
  logic stallEn, flushEn;
  assign stallEn = dValid && exStall;
  assign flushEn = brTaken && ((state == FETCH) || (state == FLUSH));

  fdc_sat_counter uStallCnt (
    .clk   (clk),
    .clrn  (clrn),
    .en    (stallEn),
    .count (stallCnt)
  );

  fdc_sat_counter uFlushCnt (
    .clk   (clk),
    .clrn  (clrn),
    .en    (flushEn),
    .count (flushCnt)
  );
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule
